// File: rtl/count_uart_reporter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count_uart_reporter_pkg                                              |
// | Shared constants, FSM state type and frame byte helper.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package count_uart_reporter_pkg;

   localparam logic [7:0]  ASCII_ZERO = 8'h30;
   localparam logic [7:0]  ASCII_CR   = 8'h0D;
   localparam logic [7:0]  ASCII_LF   = 8'h0A;
   localparam int          FRAME_LEN  = 6;
   localparam int          BCD_BIN_W  = 14;
   localparam logic [13:0] MAX_VALUE  = 14'd9999;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SNAP    = 3'd1,
      ST_CONV    = 3'd2,
      ST_LOAD    = 3'd3,
      ST_WAIT_HI = 3'd4,
      ST_WAIT_LO = 3'd5
   } rpt_state_e;

   // Byte idx of the "dddd\r\n" frame, thousands digit first.
   function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                             input logic [3:0] d3,
                                             input logic [3:0] d2,
                                             input logic [3:0] d1,
                                             input logic [3:0] d0);
      logic [7:0] b;
      case (idx)
         3'd0:    b = ASCII_ZERO + {4'b0000, d3};
         3'd1:    b = ASCII_ZERO + {4'b0000, d2};
         3'd2:    b = ASCII_ZERO + {4'b0000, d1};
         3'd3:    b = ASCII_ZERO + {4'b0000, d0};
         3'd4:    b = ASCII_CR;
         default: b = ASCII_LF;
      endcase
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/count_uart_reporter_bin2bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count_uart_reporter_bin2bcd_seq                                      |
// | Sequential binary (0..9999) to 4-digit BCD by repeated subtraction.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module count_uart_reporter_bin2bcd_seq
   import count_uart_reporter_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic [BCD_BIN_W-1:0] i_bin,
   output logic                 o_done,
   output logic [3:0]           o_d3,
   output logic [3:0]           o_d2,
   output logic [3:0]           o_d1,
   output logic [3:0]           o_d0
);

   logic                 r_active;
   logic [1:0]           r_phase;
   logic [BCD_BIN_W-1:0] r_rem;
   logic [3:0]           r_d3;
   logic [3:0]           r_d2;
   logic [3:0]           r_d1;
   logic [BCD_BIN_W-1:0] w_weight;
   logic                 w_ge;

   always_comb begin
      w_weight = 14'd10;
      case (r_phase)
         2'd0:    w_weight = 14'd1000;
         2'd1:    w_weight = 14'd100;
         default: w_weight = 14'd10;
      endcase
   end

   assign w_ge = (r_rem >= w_weight);

   // Done in the same cycle as the final tens advance, so 9999 spends 30 cycles here.
   assign o_done = r_active && (r_phase == 2'd2) && !w_ge;
   assign o_d3   = r_d3;
   assign o_d2   = r_d2;
   assign o_d1   = r_d1;
   assign o_d0   = r_rem[3:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_active <= 1'b0;
         r_phase  <= 2'd0;
         r_rem    <= '0;
         r_d3     <= 4'd0;
         r_d2     <= 4'd0;
         r_d1     <= 4'd0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_phase  <= 2'd0;
         r_rem    <= i_bin;
         r_d3     <= 4'd0;
         r_d2     <= 4'd0;
         r_d1     <= 4'd0;
      end else if (r_active) begin
         if (w_ge) begin
            r_rem <= r_rem - w_weight;
            case (r_phase)
               2'd0:    r_d3 <= r_d3 + 4'd1;
               2'd1:    r_d2 <= r_d2 + 4'd1;
               default: r_d1 <= r_d1 + 4'd1;
            endcase
         end else if (r_phase == 2'd2) begin
            r_active <= 1'b0;
         end else begin
            r_phase <= r_phase + 2'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/count_uart_reporter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count_uart_reporter                                                  |
// | Snapshots the counter on request/tick and sends "dddd\r\n" on UART.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module count_uart_reporter
   import count_uart_reporter_pkg::*;
#(
   parameter int         COUNT_W     = 14,
   parameter logic [7:0] REQ_CHAR    = 8'h53,
   parameter int         AUTO_PERIOD = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COUNT_W-1:0] count_reg,
   input  logic [7:0]         rx_data,
   input  logic               rx_done,
   input  logic               tx_busy,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   output logic               busy
);

   rpt_state_e           r_state;
   logic                 r_pending;
   logic [2:0]           r_idx;
   logic                 r_tx_start;
   logic [7:0]           r_tx_data;

   logic                 w_tick;
   logic                 w_req;
   logic                 w_conv_start;
   logic                 w_conv_done;
   logic [BCD_BIN_W-1:0] w_snap_value;
   logic [3:0]           w_d3;
   logic [3:0]           w_d2;
   logic [3:0]           w_d1;
   logic [3:0]           w_d0;

   generate
      if (AUTO_PERIOD > 0) begin : g_auto
         localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
         logic [AW-1:0] r_auto_cnt;

         assign w_tick = (r_auto_cnt == AW'(AUTO_PERIOD - 1));

         always_ff @(posedge clk) begin
            if (rst) begin
               r_auto_cnt <= '0;
            end else if (w_tick) begin
               r_auto_cnt <= '0;
            end else begin
               r_auto_cnt <= r_auto_cnt + AW'(1);
            end
         end
      end else begin : g_no_auto
         assign w_tick = 1'b0;
      end
   endgenerate

   assign w_req        = (rx_done && (rx_data == REQ_CHAR)) || w_tick;
   assign w_conv_start = (r_state == ST_SNAP);
   assign w_snap_value = (int'(count_reg) > int'(MAX_VALUE)) ? MAX_VALUE
                                                              : BCD_BIN_W'(count_reg);

   count_uart_reporter_bin2bcd_seq u_bin2bcd (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_conv_start),
      .i_bin   (w_snap_value),
      .o_done  (w_conv_done),
      .o_d3    (w_d3),
      .o_d2    (w_d2),
      .o_d1    (w_d1),
      .o_d0    (w_d0)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_pending  <= 1'b0;
         r_idx      <= 3'd0;
         r_tx_start <= 1'b0;
         r_tx_data  <= 8'h00;
      end else begin
         r_tx_start <= 1'b0;
         if (w_req && (r_state != ST_IDLE)) begin
            r_pending <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_req || r_pending) begin
                  r_state   <= ST_SNAP;
                  r_pending <= 1'b0;
               end
            end
            ST_SNAP: r_state <= ST_CONV;
            ST_CONV: begin
               if (w_conv_done) begin
                  r_state <= ST_LOAD;
                  r_idx   <= 3'd0;
               end
            end
            ST_LOAD: begin
               if (!tx_busy) begin
                  r_tx_data  <= frame_byte(r_idx, w_d3, w_d2, w_d1, w_d0);
                  r_tx_start <= 1'b1;
                  r_state    <= ST_WAIT_HI;
               end
            end
            ST_WAIT_HI: begin
               if (tx_busy) begin
                  r_state <= ST_WAIT_LO;
               end
            end
            ST_WAIT_LO: begin
               if (!tx_busy) begin
                  if (r_idx == 3'(FRAME_LEN - 1)) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_state <= ST_LOAD;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;
   assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_count_uart_reporter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_count_uart_reporter                                               |
// | Directed bench with a simple UART TX busy model per DUT instance.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_count_uart_reporter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst_a;
   logic [13:0] count_reg;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        tx_busy = 1'b0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        busy;

   logic [13:0] acount_reg;
   logic [7:0]  arx_data;
   logic        arx_done;
   logic        atx_busy = 1'b0;
   logic        atx_start;
   logic [7:0]  atx_data;
   logic        abusy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] byte_q[$];
   int         stamp_q[$];
   int         busy_cnt = 0;
   int         viol     = 0;
   logic [7:0] abyte_q[$];
   int         astamp_q[$];
   int         abusy_cnt = 0;
   int         aviol     = 0;

   always #5 clk = ~clk;

   count_uart_reporter #(.COUNT_W(14), .REQ_CHAR(8'h53), .AUTO_PERIOD(0)) u_dut (
      .clk(clk), .rst(rst), .count_reg(count_reg), .rx_data(rx_data), .rx_done(rx_done),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .busy(busy)
   );

   count_uart_reporter #(.COUNT_W(14), .REQ_CHAR(8'h53), .AUTO_PERIOD(1000)) u_dut_auto (
      .clk(clk), .rst(rst_a), .count_reg(acount_reg), .rx_data(arx_data), .rx_done(arx_done),
      .tx_busy(atx_busy), .tx_start(atx_start), .tx_data(atx_data), .busy(abusy)
   );

   always @(posedge clk) cyc++;

   // UART TX model: busy rises at the negedge after tx_start and lasts 4 more negedges.
   always @(negedge clk) begin
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (tx_start) begin
         if (tx_busy) viol++;
         byte_q.push_back(tx_data);
         stamp_q.push_back(cyc);
         tx_busy  = 1'b1;
         busy_cnt = 4;
      end
   end

   always @(negedge clk) begin
      if (abusy_cnt > 0) begin
         abusy_cnt--;
         if (abusy_cnt == 0) atx_busy = 1'b0;
      end
      if (atx_start) begin
         if (atx_busy) aviol++;
         abyte_q.push_back(atx_data);
         astamp_q.push_back(cyc);
         atx_busy  = 1'b1;
         abusy_cnt = 4;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_rx(input logic [7:0] b, output int stamp);
      @(negedge clk);
      stamp   = cyc;
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic check_frame(input string tag, input logic [7:0] q[$], input int base,
                              input logic [7:0] d3, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0);
      logic [7:0] exp [6];
      exp = '{d3, d2, d1, d0, 8'h0D, 8'h0A};
      if (q.size() >= base + 6) begin
         for (int i = 0; i < 6; i++) check($sformatf("%s_b%0d", tag, i), q[base+i], exp[i]);
      end else begin
         check({tag, "_short"}, q.size(), base + 6);
      end
   endtask

   initial begin
      int t;
      int base;
      int c0;
      int n;
      rst = 1'b1; rst_a = 1'b1;
      count_reg = 14'd0; rx_data = 8'h00; rx_done = 1'b0;
      acount_reg = 14'd1234; arx_data = 8'h00; arx_done = 1'b0;
      wait_cyc(3);
      check("rst_tx_start", tx_start, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      wait_cyc(3);

      // 1234: CONV is 2+3+4 = 9 cycles, first tx_start 3+9 cycles after the request.
      count_reg = 14'd1234;
      base = byte_q.size();
      send_rx(8'h53, t);
      wait_cyc(200);
      check("f1234_len", byte_q.size(), base + 6);
      check_frame("f1234", byte_q, base, 8'h31, 8'h32, 8'h33, 8'h34);
      if (stamp_q.size() > base) check("f1234_lat", stamp_q[base] - t, 12);

      count_reg = 14'd7;
      base = byte_q.size();
      send_rx(8'h53, t);
      wait_cyc(200);
      check_frame("f0007", byte_q, base, 8'h30, 8'h30, 8'h30, 8'h37);
      if (stamp_q.size() > base) check("f0007_lat", stamp_q[base] - t, 6);

      // 9999: CONV exactly 30 cycles.
      count_reg = 14'd9999;
      base = byte_q.size();
      send_rx(8'h53, t);
      wait_cyc(200);
      check_frame("f9999", byte_q, base, 8'h39, 8'h39, 8'h39, 8'h39);
      if (stamp_q.size() > base) check("f9999_lat", stamp_q[base] - t, 33);

      count_reg = 14'h3FFF;
      base = byte_q.size();
      send_rx(8'h53, t);
      wait_cyc(200);
      check_frame("fclamp", byte_q, base, 8'h39, 8'h39, 8'h39, 8'h39);

      // Counter moves after SNAP; frame keeps the snapshot.
      count_reg = 14'd1234;
      base = byte_q.size();
      send_rx(8'h53, t);
      @(negedge clk);
      count_reg = 14'd1300;
      wait_cyc(200);
      check("fsnap_len", byte_q.size(), base + 6);
      check_frame("fsnap", byte_q, base, 8'h31, 8'h32, 8'h33, 8'h34);

      base = byte_q.size();
      send_rx(8'h41, t);
      wait_cyc(100);
      check("ign_len", byte_q.size(), base);
      check("ign_busy", busy, 1'b0);

      // Three requests during a frame coalesce into one follow-up frame.
      count_reg = 14'd508;
      base = byte_q.size();
      send_rx(8'h53, t);
      wait_cyc(15);
      send_rx(8'h53, t);
      wait_cyc(5);
      send_rx(8'h53, t);
      wait_cyc(5);
      send_rx(8'h53, t);
      wait_cyc(300);
      check("coal_len", byte_q.size(), base + 12);
      check_frame("coal1", byte_q, base, 8'h30, 8'h35, 8'h30, 8'h38);
      check_frame("coal2", byte_q, base + 6, 8'h30, 8'h35, 8'h30, 8'h38);

      // Reset mid-frame after two bytes.
      count_reg = 14'd4321;
      base = byte_q.size();
      send_rx(8'h53, t);
      n = 0;
      while ((byte_q.size() < base + 2) && (n < 200)) begin
         @(negedge clk);
         n++;
      end
      check("mid_two_bytes", byte_q.size(), base + 2);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_start", tx_start, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      rst = 1'b0;
      wait_cyc(200);
      check("mid_no_resume", byte_q.size(), base + 2);
      base = byte_q.size();
      send_rx(8'h53, t);
      wait_cyc(200);
      check("mid_new_len", byte_q.size(), base + 6);
      check_frame("mid_new", byte_q, base, 8'h34, 8'h33, 8'h32, 8'h31);
      check("tx_while_busy", viol, 0);

      // Auto instance: ticks at 999, 1999, 2999 cycles after reset release; 'S' coincides with the third.
      @(negedge clk);
      rst_a = 1'b0;
      c0 = cyc;
      wait_cyc(2998);
      @(negedge clk);
      t = cyc;
      arx_data = 8'h53;
      arx_done = 1'b1;
      @(negedge clk);
      arx_done = 1'b0;
      wait_cyc(500);
      check("auto_len", abyte_q.size(), 18);
      if (astamp_q.size() >= 13) begin
         check("auto_first", astamp_q[0] - c0, 1011);
         check("auto_period", astamp_q[6] - astamp_q[0], 1000);
         check("auto_third", astamp_q[12] - t, 12);
      end
      check_frame("auto1", abyte_q, 0, 8'h31, 8'h32, 8'h33, 8'h34);
      check_frame("auto3", abyte_q, 12, 8'h31, 8'h32, 8'h33, 8'h34);
      check("auto_tx_while_busy", aviol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
